// File: rtl/complex_issuer.sv
// Complex-operand issuer: gathers four FP64 beats {a1,b1,a2,b2} into one request and
// serialises each {imag,real} response as two beats. Optional sticky status: COMPLEX_ISSUER_STICKY_STATUS_EN.
package complex_issuer_pkg;
  localparam int unsigned DataW = 64;
  localparam int unsigned CntW  = 4;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
endpackage

module complex_issuer
  import complex_issuer_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DataW-1:0]      s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [3:0][DataW-1:0] req_operands_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  input  logic [1:0][DataW-1:0] rsp_result_i,
  input  status_t               rsp_status_i,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  output logic [DataW-1:0]      m_data_o,
  output logic                  m_last_o,
  output status_t               m_status_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic [CntW-1:0]       outstanding_o
`ifdef COMPLEX_ISSUER_STICKY_STATUS_EN
  ,
  input  logic                  sticky_clr_i,
  output status_t               status_sticky_o
`endif
);

  localparam logic [CntW-1:0] MaxOut = CntW'(MaxOutstanding);

  typedef enum logic {COLLECT, ISSUE} gather_e;
  typedef enum logic [1:0] {IDLE, SEND_RE, SEND_IM} out_e;

  gather_e               gstate_q, gstate_d;
  out_e                  ostate_q, ostate_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [CntW-1:0]       out_d;
  logic [3:0][DataW-1:0] slot_d;
  logic [DataW-1:0]      imag_q, imag_d, m_data_d;
  status_t               m_status_d;
  logic                  m_last_d, s_ready_d, req_valid_d, rsp_ready_d, m_valid_d, busy_d;
  logic                  s_hs, req_hs, rsp_hs, m_hs;

  assign s_hs   = s_valid_i & s_ready_o;
  assign req_hs = req_valid_o & req_ready_i;
  assign rsp_hs = rsp_valid_i & rsp_ready_o;
  assign m_hs   = m_valid_o & m_ready_i;

  // Next-state and next-output computation; outputs are registered from the *_d values.
  always_comb begin
    gstate_d   = gstate_q;
    ostate_d   = ostate_q;
    cnt_d      = cnt_q;
    out_d      = outstanding_o;
    slot_d     = req_operands_o;
    imag_d     = imag_q;
    m_data_d   = m_data_o;
    m_last_d   = m_last_o;
    m_status_d = m_status_o;

    if (s_hs) begin
      slot_d[cnt_q] = s_data_i;
      cnt_d         = cnt_q + 2'd1;
      if (cnt_q == 2'd3) gstate_d = ISSUE;
    end
    if (req_hs) gstate_d = COLLECT;

    case ({req_hs, rsp_hs})
      2'b10:   out_d = outstanding_o + CntW'(1);
      2'b01:   out_d = outstanding_o - CntW'(1);
      default: out_d = outstanding_o;
    endcase

    case (ostate_q)
      IDLE: begin
        if (rsp_hs) begin
          ostate_d   = SEND_RE;
          m_data_d   = rsp_result_i[0];
          imag_d     = rsp_result_i[1];
          m_status_d = rsp_status_i;
          m_last_d   = 1'b0;
        end
      end
      SEND_RE: begin
        if (m_hs) begin
          ostate_d = SEND_IM;
          m_data_d = imag_q;
          m_last_d = 1'b1;
        end
      end
      SEND_IM: begin
        if (m_hs) begin
          ostate_d = IDLE;
          m_last_d = 1'b0;
        end
      end
      default: ostate_d = IDLE;
    endcase

    // Flush wins over every handshake of its cycle.
    if (flush_i) begin
      gstate_d   = COLLECT;
      ostate_d   = IDLE;
      cnt_d      = 2'd0;
      out_d      = '0;
      slot_d     = '0;
      imag_d     = '0;
      m_data_d   = '0;
      m_last_d   = 1'b0;
      m_status_d = '0;
    end

    s_ready_d   = (gstate_d == COLLECT);
    req_valid_d = (gstate_d == ISSUE) && (out_d < MaxOut);
    rsp_ready_d = (out_d != '0) && (ostate_d == IDLE);
    m_valid_d   = (ostate_d != IDLE);
    busy_d      = (cnt_d != 2'd0) || (gstate_d == ISSUE) || (out_d != '0) || (ostate_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gstate_q       <= COLLECT;
      ostate_q       <= IDLE;
      cnt_q          <= 2'd0;
      outstanding_o  <= '0;
      req_operands_o <= '0;
      imag_q         <= '0;
      m_data_o       <= '0;
      m_last_o       <= 1'b0;
      m_status_o     <= '0;
      s_ready_o      <= 1'b1;
      req_valid_o    <= 1'b0;
      rsp_ready_o    <= 1'b0;
      m_valid_o      <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      gstate_q       <= gstate_d;
      ostate_q       <= ostate_d;
      cnt_q          <= cnt_d;
      outstanding_o  <= out_d;
      req_operands_o <= slot_d;
      imag_q         <= imag_d;
      m_data_o       <= m_data_d;
      m_last_o       <= m_last_d;
      m_status_o     <= m_status_d;
      s_ready_o      <= s_ready_d;
      req_valid_o    <= req_valid_d;
      rsp_ready_o    <= rsp_ready_d;
      m_valid_o      <= m_valid_d;
      busy_o         <= busy_d;
    end
  end

`ifdef COMPLEX_ISSUER_STICKY_STATUS_EN
  status_t sticky_d;

  // A clear coinciding with a response keeps only that response's flags.
  always_comb begin
    sticky_d = status_sticky_o;
    if (sticky_clr_i) sticky_d = rsp_hs ? rsp_status_i : '0;
    else if (rsp_hs)  sticky_d = status_t'(status_sticky_o | rsp_status_i);
    if (flush_i)      sticky_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) status_sticky_o <= '0;
    else         status_sticky_o <= sticky_d;
  end
`endif

endmodule

// File: doc/complex_issuer.md
COMPLEX_ISSUER -- requirements
Module: complex_issuer

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, max requests issued but not yet answered (range 1..15).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port s_data_i, input, 64, operand word stream; beat order a1, b1, a2, b2 (FP64).
REQ-005 SHALL have ports s_valid_i (input, 1) and s_ready_o (output, 1), operand stream handshake.
REQ-006 SHALL have port req_operands_o, output, [3:0][64], packed {b2,a2,b1,a1}, to the complex arithmetic unit.
REQ-007 SHALL have ports req_valid_o (output, 1) and req_ready_i (input, 1), request handshake.
REQ-008 SHALL have port rsp_result_i, input, [1:0][64], {imag,real} result from the unit.
REQ-009 SHALL have port rsp_status_i, input, fpnew_pkg::status_t (5), result status flags.
REQ-010 SHALL have ports rsp_valid_i (input, 1) and rsp_ready_o (output, 1), response handshake.
REQ-011 SHALL have ports m_data_o (output, 64), m_last_o (output, 1), m_status_o (output, status_t), result stream.
REQ-012 SHALL have ports m_valid_o (output, 1) and m_ready_i (input, 1), result stream handshake.
REQ-013 SHALL have ports flush_i (input, 1), busy_o (output, 1), outstanding_o (output, 4).

Function
REQ-014 Handshake on any interface SHALL occur in a cycle where valid and ready are both high; asserted valid and its data SHALL stay stable until handshake.
REQ-015 Gather FSM states COLLECT, ISSUE; 2-bit beat counter; in COLLECT s_ready_o=1, each handshake stores s_data_i into slot[counter] and increments.
REQ-016 Handshake on beat 3 SHALL go COLLECT->ISSUE and clear the counter; req_valid_o SHALL assert the next cycle (1-cycle latency).
REQ-017 In ISSUE s_ready_o=0; req_valid_o=1 only while outstanding_o < MaxOutstanding; once asserted it SHALL hold until req_ready_i.
REQ-018 Request handshake SHALL return to COLLECT and increment outstanding; response handshake SHALL decrement it; both in one cycle SHALL leave it unchanged.
REQ-019 rsp_ready_o SHALL be 1 only when outstanding_o > 0 and output FSM is IDLE; rsp_valid_i with outstanding_o=0 SHALL be ignored.
REQ-020 Output FSM states IDLE, SEND_RE, SEND_IM; response handshake captures result and status and goes SEND_RE; m_valid_o asserts next cycle.
REQ-021 SEND_RE drives real part, m_last_o=0; on handshake -> SEND_IM, drives imag part, m_last_o=1; on handshake -> IDLE. m_status_o = captured status on both beats.
REQ-022 Response handshake and a request handshake SHALL proceed independently in the same cycle.
REQ-023 busy_o = (beat counter != 0) | ISSUE | (outstanding_o != 0) | (output FSM != IDLE).
REQ-024 flush_i SHALL be synchronous, override all handshakes in its cycle, and return every register to reset values next cycle (partial beats and captured result dropped).

Reset
REQ-025 On rst_ni low, asynchronously: COLLECT, counter 0, IDLE, outstanding_o=0, operand and result registers 0.
REQ-026 Output reset values: s_ready_o=1, req_valid_o=0, rsp_ready_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, m_status_o=0, busy_o=0, req_operands_o=0.
REQ-027 Reset asserted mid-transfer SHALL discard everything; no spurious handshake after release.

Configuration
REQ-028 Macro COMPLEX_ISSUER_STICKY_STATUS_EN defined: ports sticky_clr_i (input, 1) and status_sticky_o (output, status_t) exist; status_sticky_o ORs rsp_status_i at every response handshake.
REQ-029 With macro: reset, flush_i or sticky_clr_i clear it; clear plus response in one cycle SHALL load rsp_status_i alone.
REQ-030 Macro undefined: both ports absent, no sticky logic; all other behaviour identical.

Verification
REQ-031 Beats 1.0,2.0,3.0,4.0 with continuous valid -> req_valid_o at cycle after beat 4, req_operands_o={4.0,3.0,2.0,1.0}.
REQ-032 MaxOutstanding=2, rsp_valid_i=0, 12 beats -> two requests accepted, third held with req_valid_o=0, s_ready_o=0, outstanding_o=2.
REQ-033 Response {imag=-0.5, real=0.25}, status NX, m_ready_i=1 -> m_data_o 0.25 (last 0) then -0.5 (last 1), m_status_o=NX both beats, outstanding decrements.
REQ-034 Request and response handshakes same cycle at outstanding_o=1 -> stays 1; rsp_valid_i at outstanding_o=0 -> rsp_ready_o=0, no output.
REQ-035 flush_i after 2 beats with 1 outstanding -> next cycle counter 0, outstanding_o=0, busy_o=0; new 4 beats issue normally.
REQ-036 Macro defined: responses NX then DZ -> status_sticky_o=NX|DZ; sticky_clr_i with response OF same cycle -> OF only.
